// File: rtl/mult_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mult_operand_sequencer
//  Purpose  : Transaction wrapper around a free-running repeated-add
//             multiplier. Accepts an operand pair over valid/ready, holds it
//             on the multiplier inputs for a settle time derived from the
//             multiplier operand, samples the product and offers it
//             downstream over valid/ready. One transaction in flight.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK, RST          clock (rising edge), asynchronous active-high reset
//    in_valid/in_ready operand handshake; in_a multiplicand, in_b multiplier
//    mul_multiplicand  operands driven to the multiplier, held until the
//    mul_multiplier    next accepted pair (never cleared except by reset)
//    mul_product       product returned by the multiplier
//    out_valid/ready   result handshake
//    out_product       sampled product; out_a/out_b the operands behind it
//    busy              high while a transaction is in flight (DRIVE/HOLD)
// ============================================================================
module mult_operand_sequencer #(
    parameter int WIDTH_IN     = 8,
    parameter int WIDTH_OUT    = 16,
    parameter int SETTLE_EXTRA = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_IN-1:0]  in_a,
    input  logic [WIDTH_IN-1:0]  in_b,
    output logic [WIDTH_IN-1:0]  mul_multiplicand,
    output logic [WIDTH_IN-1:0]  mul_multiplier,
    input  logic [WIDTH_OUT-1:0] mul_product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_OUT-1:0] out_product,
    output logic [WIDTH_IN-1:0]  out_a,
    output logic [WIDTH_IN-1:0]  out_b,
    output logic                 busy
);

    // Four spare bits keep in_b + SETTLE_EXTRA - 1 from wrapping for any
    // in_b, since SETTLE_EXTRA never exceeds 15.
    localparam int CW = WIDTH_IN + 4;
    localparam logic [CW-1:0] c_settle_m1 = CW'(SETTLE_EXTRA - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_accept;
    logic                   w_capture;
    logic [CW-1:0]          r_count;
    logic [WIDTH_IN-1:0]    r_mul_a;
    logic [WIDTH_IN-1:0]    r_mul_b;
    logic [WIDTH_IN-1:0]    r_out_a;
    logic [WIDTH_IN-1:0]    r_out_b;
    logic [WIDTH_OUT-1:0]   r_out_product;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath enables
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // Counter was loaded with settle-1, so reaching zero marks
                // the last DRIVE cycle and the product is sampled here.
                if (r_count == '0) begin
                    w_capture = 1'b1;
                    w_next    = S_HOLD;
                end
            end
            S_HOLD: begin
                // Release returns to IDLE only; new input waits one edge.
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count       <= '0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_out_a       <= '0;
            r_out_b       <= '0;
            r_out_product <= '0;
        end else begin
            if (w_accept) begin
                r_mul_a <= in_a;
                r_mul_b <= in_b;
                r_out_a <= in_a;
                r_out_b <= in_b;
                r_count <= {4'b0000, in_b} + c_settle_m1;
            end else if (r_state == S_DRIVE && !w_capture) begin
                r_count <= r_count - 1'b1;
            end
            if (w_capture) begin
                r_out_product <= mul_product;
            end
        end
    end

    // Handshake flags decode straight from the state register so that an
    // asynchronous reset drops them without waiting for a clock edge.
    assign in_ready         = (r_state == S_IDLE);
    assign out_valid        = (r_state == S_HOLD);
    assign busy             = (r_state != S_IDLE);
    assign mul_multiplicand = r_mul_a;
    assign mul_multiplier   = r_mul_b;
    assign out_product      = r_out_product;
    assign out_a            = r_out_a;
    assign out_b            = r_out_b;

endmodule
`default_nettype wire

// File: tb/tb_mult_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_operand_sequencer
//  Purpose  : Scoreboard bench for mult_operand_sequencer. Includes a
//             behavioural repeated-add multiplier that restarts whenever its
//             operands change and adds the multiplicand once per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_operand_sequencer;

    localparam int WI = 8;
    localparam int WO = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WI-1:0] in_a = '0;
    logic [WI-1:0] in_b = '0;
    logic [WI-1:0] mul_multiplicand;
    logic [WI-1:0] mul_multiplier;
    logic [WO-1:0] mul_product;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [WO-1:0] out_product;
    logic [WI-1:0] out_a;
    logic [WI-1:0] out_b;
    logic          busy;

    mult_operand_sequencer #(
        .WIDTH_IN     (WI),
        .WIDTH_OUT    (WO),
        .SETTLE_EXTRA (2)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .out_a            (out_a),
        .out_b            (out_b),
        .busy             (busy)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Behavioural repeated-add multiplier
    // ------------------------------------------------------------------
    logic [WI-1:0] m_a, m_b, m_cnt;
    logic [WO-1:0] m_acc;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_a <= '0; m_b <= '0; m_cnt <= '0; m_acc <= '0;
        end else if (mul_multiplicand != m_a || mul_multiplier != m_b) begin
            m_a   <= mul_multiplicand;
            m_b   <= mul_multiplier;
            m_cnt <= mul_multiplier;
            m_acc <= '0;
        end else if (m_cnt != 0) begin
            m_acc <= m_acc + WO'(m_a);
            m_cnt <= m_cnt - 1'b1;
        end
    end
    assign mul_product = m_acc;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [WI-1:0] a;
        logic [WI-1:0] b;
        logic [WO-1:0] p;
        int            lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: measures acceptance-to-valid latency and checks each result
    // at its output handshake.
    int   accept_cyc = 0;
    int   meas_lat   = 0;
    logic prev_ov    = 1'b0;
    initial begin
        forever begin
            @(negedge CLK);
            if (in_valid && in_ready && !RST) accept_cyc = cyc + 1;
            if (out_valid && !prev_ov) meas_lat = cyc - accept_cyc;
            prev_ov = out_valid;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_product", out_product, e.p);
                    chk("out_a", out_a, e.a);
                    chk("out_b", out_b, e.b);
                    chk("latency", meas_lat, e.lat);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic send(input logic [WI-1:0] a, input logic [WI-1:0] b,
                        input logic [WO-1:0] p);
        exp_t e;
        int   n;
        @(posedge CLK); #1;
        in_a = a; in_b = b; in_valid = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!in_ready && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        e.a = a; e.b = b; e.p = p; e.lat = int'(b) + 2;
        exp_q.push_back(e);
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        exp_t e;
        logic [7:0] sa[7] = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd254, 8'd255};
        logic [7:0] sb[5] = '{8'd0, 8'd1, 8'd2, 8'd17, 8'd128};

        // Reset
        repeat (5) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_multiplicand", mul_multiplicand, 0);
        chk("rst_mul_multiplier", mul_multiplier, 0);
        chk("rst_out_product", out_product, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);

        // Directed transactions and boundaries
        send(8'd13, 8'd11, 16'd143);
        drain();
        send(8'd255, 8'd255, 16'd65025);
        drain();
        send(8'd0, 8'd0, 16'd0);
        drain();
        send(8'd255, 8'd0, 16'd0);
        drain();

        // Backpressure
        out_ready = 1'b0;
        send(8'd9, 8'd6, 16'd54);
        n = 0;
        while (!out_valid && n < 1000) begin @(negedge CLK); n++; end
        chk("bp_valid_seen", out_valid, 1);
        @(posedge CLK); #1;
        in_a = 8'd7; in_b = 8'd3; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_product", out_product, 54);
            chk("bp_mul_multiplier", mul_multiplier, 6);
        end
        @(posedge CLK); #1;
        out_ready = 1'b1;
        e.a = 8'd7; e.b = 8'd3; e.p = 16'd21; e.lat = 5;
        exp_q.push_back(e);
        @(negedge CLK);
        chk("bp_in_ready_after_release", in_ready, 0);
        @(negedge CLK);
        chk("bp_idle_in_ready", in_ready, 1);
        @(negedge CLK);
        chk("bp_accepted_busy", busy, 1);
        chk("bp_accepted_mul_multiplier", mul_multiplier, 3);
        in_valid = 1'b0;
        drain();

        // Asynchronous reset mid-DRIVE
        send(8'd200, 8'd200, 16'd40000);
        repeat (50) @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_mul_multiplicand", mul_multiplicand, 0);
        chk("arst_mul_multiplier", mul_multiplier, 0);
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        send(8'd3, 8'd4, 16'd12);
        drain();

        // Reduced sweep of corner operand values, back-to-back
        foreach (sa[i]) begin
            foreach (sb[j]) begin
                send(sa[i], sb[j], WO'(sa[i]) * WO'(sb[j]));
            end
        end
        drain();

        repeat (3) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
